// File: rtl/logic_proc_pkg.sv
// Shared types for the serial bitwise logic processor: function codes,
// routing codes, FSM states and the single-bit function evaluator.
package logic_proc_pkg;

    typedef enum logic [2:0] {
        F_AND   = 3'b000,
        F_OR    = 3'b001,
        F_XOR   = 3'b010,
        F_ONES  = 3'b011,
        F_NAND  = 3'b100,
        F_NOR   = 3'b101,
        F_XNOR  = 3'b110,
        F_ZEROS = 3'b111
    } func_t;

    typedef enum logic [1:0] {
        R_KEEP = 2'b00,
        R_TO_B = 2'b01,
        R_TO_A = 2'b10,
        R_SWAP = 2'b11
    } route_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        HOLD  = 2'b10
    } state_t;

    function automatic logic bit_func(input func_t f, input logic a, input logic b);
        case (f)
            F_AND:   return a & b;
            F_OR:    return a | b;
            F_XOR:   return a ^ b;
            F_ONES:  return 1'b1;
            F_NAND:  return ~(a & b);
            F_NOR:   return ~(a | b);
            F_XNOR:  return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/logic_slice_unit.sv
// Combinational K-bit slice: applies the selected bitwise function to the
// outgoing A/B LSB slices and routes the result into the new MSB slices.
module logic_slice_unit
    import logic_proc_pkg::*;
#(
    parameter int K = 1
) (
    input  logic [K-1:0] a_slice,
    input  logic [K-1:0] b_slice,
    input  func_t        f,
    input  route_t       r,
    output logic [K-1:0] a_new,
    output logic [K-1:0] b_new
);

    logic [K-1:0] res;

    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_bit
            assign res[gi] = bit_func(f, a_slice[gi], b_slice[gi]);
        end
    endgenerate

    always_comb begin
        a_new = a_slice;
        b_new = b_slice;
        case (r)
            R_TO_B: b_new = res;
            R_TO_A: a_new = res;
            R_SWAP: begin
                a_new = b_slice;
                b_new = a_slice;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/logic_processor_n.sv
// Serial bitwise logic processor: A/B registers rotate right by K bits per
// clock, so after N = WIDTH/K shifts every slice has been processed once.
module logic_processor_n
    import logic_proc_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LoadA,
    input  logic             LoadB,
    input  logic             Execute,
    input  logic [WIDTH-1:0] Din,
    input  logic [2:0]       F,
    input  logic [1:0]       R,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Busy,
    output logic             Done
);

    localparam int K  = BITS_PER_CYCLE;
    localparam int N  = WIDTH / K;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [CW-1:0]    count_reg, count_next;
    func_t            f_reg, f_next;
    route_t           r_reg, r_next;
    logic             done_reg, done_next;

    logic [K-1:0]       a_new, b_new;
    logic [WIDTH+K-1:0] a_cat, b_cat;

    logic_slice_unit #(.K(K)) u_slice (
        .a_slice (a_reg[K-1:0]),
        .b_slice (b_reg[K-1:0]),
        .f       (f_reg),
        .r       (r_reg),
        .a_new   (a_new),
        .b_new   (b_new)
    );

    // Concatenate-then-select keeps the shift legal even when K == WIDTH.
    assign a_cat = {a_new, a_reg};
    assign b_cat = {b_new, b_reg};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            count_reg <= '0;
            f_reg     <= F_AND;
            r_reg     <= R_KEEP;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            count_reg <= count_next;
            f_reg     <= f_next;
            r_reg     <= r_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        count_next = count_reg;
        f_next     = f_reg;
        r_next     = r_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (LoadA) a_next = Din;
                if (LoadB) b_next = Din;
                if (Execute) begin
                    f_next     = func_t'(F);
                    r_next     = route_t'(R);
                    count_next = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                a_next = a_cat[WIDTH+K-1:K];
                b_next = b_cat[WIDTH+K-1:K];
                if (count_reg == LAST) begin
                    count_next = '0;
                    done_next  = 1'b1;
                    state_next = HOLD;
                end else begin
                    count_next = count_reg + CW'(1);
                end
            end
            HOLD: begin
                // Wait for Execute to drop so a held request fires only once.
                if (!Execute) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign Aval = a_reg;
    assign Bval = b_reg;
    assign Busy = (state_reg == SHIFT);
    assign Done = done_reg;

endmodule
